ctrl_conv_input: RTL and testbench
==================================

// Module: ctrl_conv_input
// PURPOSE
//  Input-side control for the 1-D convolution engine. Accepts the input vector X and filter
//  F over two independent valid/ready streams and writes them into X memory and F memory.
//  Asserts conv_start to the output controller once both memories are full; holds it until
//  that controller pulses conv_done. Then rearms for the next frame.
//  Sits directly upstream of the output/MAC control stage.
// PARAMETERS
//  X_LEN   20  number of X samples per frame
//  F_LEN   13  number of filter taps per frame
//  DATA_W  20  sample/tap width in bits
//  XA_W    5   X memory address width, = $clog2(X_LEN)
//  FA_W    4   F memory address width, = $clog2(F_LEN)
// PORTS
//  clk           in   1       clock, all state on rising edge
//  reset         in   1       asynchronous, active-low reset
//  s_valid_x     in   1       X stream valid
//  s_ready_x     out  1       X stream ready
//  s_data_x      in   DATA_W  X stream sample
//  s_valid_f     in   1       F stream valid
//  s_ready_f     out  1       F stream ready
//  s_data_f      in   DATA_W  F stream tap
//  xmem_wr_en    out  1       X memory write enable
//  xmem_wr_addr  out  XA_W    X memory write address
//  xmem_wr_data  out  DATA_W  X memory write data (= s_data_x)
//  fmem_wr_en    out  1       F memory write enable
//  fmem_wr_addr  out  FA_W    F memory write address
//  fmem_wr_data  out  DATA_W  F memory write data (= s_data_f)
//  conv_start    out  1       both memories loaded; convolution may run
//  conv_done     in   1       1-cycle pulse from the output controller: last y accepted
// BEHAVIOUR
//  - Reset (reset=0, async): state=LOAD, x_cnt=0, f_cnt=0, x_full=0, f_full=0, conv_start=0.
//    Both readys are 0 while reset is asserted. All wr_en outputs are 0.
//  - FSM, registered:
//    - LOAD: conv_start=0.
//      - s_ready_x = ~x_full. s_ready_f = ~f_full.
//      - When x_full and f_full are both 1: go to RUN.
//    - RUN: conv_start=1. s_ready_x=0, s_ready_f=0.
//      - On conv_done=1: go to LOAD and clear x_cnt, f_cnt, x_full, f_full.
//      - conv_start is 0 in the cycle after conv_done.
//  - X write: xmem_wr_en = s_valid_x & s_ready_x (combinational).
//    - xmem_wr_addr = x_cnt. On a write, x_cnt increments.
//    - The write at x_cnt = X_LEN-1 sets x_full and holds x_cnt at X_LEN-1. There is no wrap.
//  - F write: same rules with f_cnt / F_LEN / f_full. Taps are stored at addresses 0..F_LEN-1
//    in arrival order.
//  - The X and F streams are fully independent.
//    - Either stream may finish first; the finished stream holds ready low.
//    - Both may finish in the same cycle.
//  - Latency: conv_start rises one clk after the later of the two final writes is accepted.
//  - Data is never dropped. While s_ready_* = 0, the source must hold valid and data stable.
//  - conv_done while in LOAD is ignored: no state change, counters untouched.
//  - conv_done and a valid arriving in the same RUN cycle: the valid is not accepted (ready=0).
//    The next frame's first beat is accepted in LOAD from the following cycle.
//  - Reset mid-load or mid-run: partial frame is discarded, conv_start drops immediately,
//    and the next frame starts at address 0.
//  - The memories must not be written while conv_start=1. The RUN state guarantees this.
// TESTING
//  1. Reset, then X: 20 beats back-to-back, then F: 13 beats.
//     -> xmem addr 0..19, fmem addr 0..12, data in order.
//     -> conv_start=1 one cycle after F beat 13.
//  2. X and F interleaved with random valid gaps, F finishing first.
//     -> s_ready_f=0 after tap 13, conv_start only after X beat 20.
//  3. Last X beat and last F beat in the same cycle.
//     -> conv_start=1 next cycle; no extra writes.
//  4. In RUN, hold s_valid_x=1 and pulse conv_done.
//     -> no write during RUN; conv_start=0 next cycle.
//     -> next frame's X beat 0 written to addr 0.
//  5. conv_done pulsed during LOAD after 7 X beats.
//     -> x_cnt stays 7; the 8th beat is written to addr 7.
//  6. Async reset=0 after 10 X beats and 5 F beats.
//     -> conv_start=0, readys=0 during reset; after release, writes restart at addr 0.

Source files
------------

// File: rtl/ctrl_conv_input_if.sv
// Bus bundle between the convolution input controller and its environment:
// X/F input streams, X/F memory write ports and the start/done handshake.
interface ctrl_conv_input_if #(
    parameter int unsigned DATA_W = 20,
    parameter int unsigned XA_W   = 5,
    parameter int unsigned FA_W   = 4
);
    logic              s_valid_x;
    logic              s_ready_x;
    logic [DATA_W-1:0] s_data_x;
    logic              s_valid_f;
    logic              s_ready_f;
    logic [DATA_W-1:0] s_data_f;

    logic              xmem_wr_en;
    logic [XA_W-1:0]   xmem_wr_addr;
    logic [DATA_W-1:0] xmem_wr_data;
    logic              fmem_wr_en;
    logic [FA_W-1:0]   fmem_wr_addr;
    logic [DATA_W-1:0] fmem_wr_data;

    logic              conv_start;
    logic              conv_done;

    // Environment side: stream sources and the output controller
    modport master (
        output s_valid_x, s_data_x, s_valid_f, s_data_f, conv_done,
        input  s_ready_x, s_ready_f,
        input  xmem_wr_en, xmem_wr_addr, xmem_wr_data,
        input  fmem_wr_en, fmem_wr_addr, fmem_wr_data,
        input  conv_start
    );

    // Controller side
    modport slave (
        input  s_valid_x, s_data_x, s_valid_f, s_data_f, conv_done,
        output s_ready_x, s_ready_f,
        output xmem_wr_en, xmem_wr_addr, xmem_wr_data,
        output fmem_wr_en, fmem_wr_addr, fmem_wr_data,
        output conv_start
    );
endinterface

// File: rtl/ctrl_conv_input.sv
// Input-side control for the 1-D convolution engine: loads one frame of X samples
// and F taps into their memories, then holds conv_start until conv_done.
module ctrl_conv_input #(
    parameter int unsigned X_LEN  = 20,
    parameter int unsigned F_LEN  = 13,
    parameter int unsigned DATA_W = 20,
    parameter int unsigned XA_W   = 5,
    parameter int unsigned FA_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    ctrl_conv_input_if.slave   bus
);
    localparam logic [XA_W-1:0] X_LAST = XA_W'(X_LEN - 1);
    localparam logic [FA_W-1:0] F_LAST = FA_W'(F_LEN - 1);

    typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [XA_W-1:0] x_cnt_q, x_cnt_d;
    logic [FA_W-1:0] f_cnt_q, f_cnt_d;
    logic            x_full_q, x_full_d;
    logic            f_full_q, f_full_d;

    logic            x_rdy, f_rdy;
    logic            x_wr, f_wr;

    // Readys come from registered state; the reset term keeps them low while reset is held
    assign x_rdy = reset & (state_q == LOAD) & ~x_full_q;
    assign f_rdy = reset & (state_q == LOAD) & ~f_full_q;
    assign x_wr  = bus.s_valid_x & x_rdy;
    assign f_wr  = bus.s_valid_f & f_rdy;

    assign bus.s_ready_x    = x_rdy;
    assign bus.s_ready_f    = f_rdy;
    assign bus.xmem_wr_en   = x_wr;
    assign bus.xmem_wr_addr = x_cnt_q;
    assign bus.xmem_wr_data = bus.s_data_x;
    assign bus.fmem_wr_en   = f_wr;
    assign bus.fmem_wr_addr = f_cnt_q;
    assign bus.fmem_wr_data = bus.s_data_f;
    assign bus.conv_start   = (state_q == RUN);

    // State and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= LOAD;
            x_cnt_q  <= '0;
            f_cnt_q  <= '0;
            x_full_q <= 1'b0;
            f_full_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_cnt_q  <= x_cnt_d;
            f_cnt_q  <= f_cnt_d;
            x_full_q <= x_full_d;
            f_full_q <= f_full_d;
        end
    end

    // Next-state: counters saturate at the last address; RUN is entered on the
    // same edge that accepts the later final beat.
    always_comb begin
        state_d  = state_q;
        x_cnt_d  = x_cnt_q;
        f_cnt_d  = f_cnt_q;
        x_full_d = x_full_q;
        f_full_d = f_full_q;

        case (state_q)
            LOAD: begin
                if (x_wr) begin
                    if (x_cnt_q == X_LAST) x_full_d = 1'b1;
                    else                   x_cnt_d  = x_cnt_q + XA_W'(1);
                end
                if (f_wr) begin
                    if (f_cnt_q == F_LAST) f_full_d = 1'b1;
                    else                   f_cnt_d  = f_cnt_q + FA_W'(1);
                end
                if (x_full_d && f_full_d) state_d = RUN;
            end
            RUN: begin
                if (bus.conv_done) begin
                    state_d  = LOAD;
                    x_cnt_d  = '0;
                    f_cnt_d  = '0;
                    x_full_d = 1'b0;
                    f_full_d = 1'b0;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_ctrl_conv_input.sv
// Directed bench for ctrl_conv_input: a vector table for the first frame and
// the RUN/done handoff, then hand-written sequences for the multi-cycle corners.
module tb_ctrl_conv_input;
    logic clk;
    logic reset;

    ctrl_conv_input_if #(.DATA_W(20), .XA_W(5), .FA_W(4)) bus ();

    ctrl_conv_input #(
        .X_LEN(20), .F_LEN(13), .DATA_W(20), .XA_W(5), .FA_W(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vx;
        logic [19:0] dx;
        logic        vf;
        logic [19:0] df;
        logic        done;
        logic        rx;
        logic        rf;
        logic        xwe;
        logic [4:0]  xa;
        logic        fwe;
        logic [3:0]  fa;
        logic        st;
    } vec_t;

    localparam int NVEC = 36;
    vec_t tbl [NVEC];

    int n_vec;
    int n_mis;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tg, input logic rx, input logic rf, input logic xwe,
                           input logic [4:0] xa, input logic fwe, input logic [3:0] fa,
                           input logic st);
        chk({tg, ".ready_x"},    32'(bus.s_ready_x),    32'(rx));
        chk({tg, ".ready_f"},    32'(bus.s_ready_f),    32'(rf));
        chk({tg, ".xmem_we"},    32'(bus.xmem_wr_en),   32'(xwe));
        chk({tg, ".xmem_addr"},  32'(bus.xmem_wr_addr), 32'(xa));
        chk({tg, ".fmem_we"},    32'(bus.fmem_wr_en),   32'(fwe));
        chk({tg, ".fmem_addr"},  32'(bus.fmem_wr_addr), 32'(fa));
        chk({tg, ".conv_start"}, 32'(bus.conv_start),   32'(st));
        if (xwe) chk({tg, ".xmem_data"}, 32'(bus.xmem_wr_data), 32'(bus.s_data_x));
        if (fwe) chk({tg, ".fmem_data"}, 32'(bus.fmem_wr_data), 32'(bus.s_data_f));
    endtask

    // Drive one cycle's inputs at the falling edge; outputs settle 1 time unit later
    task automatic cyc(input logic vx, input logic [19:0] dx, input logic vf,
                       input logic [19:0] df, input logic done);
        @(negedge clk);
        bus.s_valid_x = vx;
        bus.s_data_x  = dx;
        bus.s_valid_f = vf;
        bus.s_data_f  = df;
        bus.conv_done = done;
        #1;
    endtask

    initial begin
        int xi;
        int fi;
        logic vx;
        logic vf;
        n_vec = 0;
        n_mis = 0;

        // Frame 1: 20 X beats back-to-back, then 13 F beats, then RUN and conv_done
        for (int i = 0; i < 20; i++)
            tbl[i] = '{vx: 1'b1, dx: 20'(100 + i), vf: 1'b0, df: 20'h0, done: 1'b0,
                       rx: 1'b1, rf: 1'b1, xwe: 1'b1, xa: 5'(i), fwe: 1'b0, fa: 4'd0, st: 1'b0};
        for (int j = 0; j < 13; j++)
            tbl[20 + j] = '{vx: 1'b0, dx: 20'h0, vf: 1'b1, df: 20'(500 + j), done: 1'b0,
                            rx: 1'b0, rf: 1'b1, xwe: 1'b0, xa: 5'd19, fwe: 1'b1, fa: 4'(j), st: 1'b0};
        tbl[33] = '{vx: 1'b1, dx: 20'hABCDE, vf: 1'b1, df: 20'h12345, done: 1'b0,
                    rx: 1'b0, rf: 1'b0, xwe: 1'b0, xa: 5'd19, fwe: 1'b0, fa: 4'd12, st: 1'b1};
        tbl[34] = '{vx: 1'b1, dx: 20'hABCDE, vf: 1'b0, df: 20'h0, done: 1'b1,
                    rx: 1'b0, rf: 1'b0, xwe: 1'b0, xa: 5'd19, fwe: 1'b0, fa: 4'd12, st: 1'b1};
        tbl[35] = '{vx: 1'b1, dx: 20'hABCDE, vf: 1'b0, df: 20'h0, done: 1'b0,
                    rx: 1'b1, rf: 1'b1, xwe: 1'b1, xa: 5'd0, fwe: 1'b0, fa: 4'd0, st: 1'b0};

        reset = 1'b0;
        bus.s_valid_x = 1'b0;
        bus.s_data_x  = '0;
        bus.s_valid_f = 1'b0;
        bus.s_data_f  = '0;
        bus.conv_done = 1'b0;
        #1;
        chk_out("reset", 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < NVEC; k++) begin
            cyc(tbl[k].vx, tbl[k].dx, tbl[k].vf, tbl[k].df, tbl[k].done);
            chk_out($sformatf("vec%0d", k), tbl[k].rx, tbl[k].rf, tbl[k].xwe, tbl[k].xa,
                    tbl[k].fwe, tbl[k].fa, tbl[k].st);
        end

        // Interleaved streams with gaps; F finishes first and is then held valid
        xi = 1;
        fi = 0;
        for (int c = 0; c < 200 && xi < 20; c++) begin
            vx = ((c % 3) == 0);
            vf = (fi >= 13) ? 1'b1 : ((c % 2) == 0);
            cyc(vx, 20'(200 + xi), vf, 20'(300 + fi), 1'b0);
            chk_out($sformatf("ilv%0d", c), 1'b1, (fi < 13), vx, 5'(xi),
                    vf && (fi < 13), (fi < 13) ? 4'(fi) : 4'd12, 1'b0);
            if (vx) xi++;
            if (vf && fi < 13) fi++;
        end
        cyc(1'b0, 20'h0, 1'b1, 20'h0, 1'b0);
        chk_out("ilv_run", 1'b0, 1'b0, 1'b0, 5'd19, 1'b0, 4'd12, 1'b1);
        cyc(1'b0, 20'h0, 1'b0, 20'h0, 1'b1);
        chk_out("ilv_done", 1'b0, 1'b0, 1'b0, 5'd19, 1'b0, 4'd12, 1'b1);

        // Final X and F beats land in the same cycle
        for (int c = 0; c < 20; c++) begin
            vf = (c >= 7);
            cyc(1'b1, 20'(700 + c), vf, 20'(800 + c), 1'b0);
            chk_out($sformatf("same%0d", c), 1'b1, 1'b1, 1'b1, 5'(c), vf,
                    (c >= 7) ? 4'(c - 7) : 4'd0, 1'b0);
        end
        cyc(1'b1, 20'h11111, 1'b1, 20'h22222, 1'b0);
        chk_out("same_run", 1'b0, 1'b0, 1'b0, 5'd19, 1'b0, 4'd12, 1'b1);
        cyc(1'b0, 20'h0, 1'b0, 20'h0, 1'b1);
        chk_out("same_done", 1'b0, 1'b0, 1'b0, 5'd19, 1'b0, 4'd12, 1'b1);

        // conv_done in LOAD after 7 X beats must be ignored
        for (int c = 0; c < 7; c++) begin
            cyc(1'b1, 20'(900 + c), 1'b0, 20'h0, 1'b0);
            chk_out($sformatf("ign%0d", c), 1'b1, 1'b1, 1'b1, 5'(c), 1'b0, 4'd0, 1'b0);
        end
        cyc(1'b0, 20'h0, 1'b0, 20'h0, 1'b1);
        chk_out("ign_done", 1'b1, 1'b1, 1'b0, 5'd7, 1'b0, 4'd0, 1'b0);
        cyc(1'b1, 20'd907, 1'b0, 20'h0, 1'b0);
        chk_out("ign_beat8", 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 4'd0, 1'b0);

        // Reach 10 X and 5 F beats, then assert reset mid-load
        for (int c = 0; c < 5; c++) begin
            vx = (c < 2);
            cyc(vx, 20'(908 + c), 1'b1, 20'(950 + c), 1'b0);
            chk_out($sformatf("pre_rst%0d", c), 1'b1, 1'b1, vx,
                    (c < 2) ? 5'(8 + c) : 5'd10, 1'b1, 4'(c), 1'b0);
        end
        @(negedge clk);
        bus.s_valid_x = 1'b1;
        bus.s_valid_f = 1'b1;
        reset = 1'b0;
        #1;
        chk_out("in_rst", 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        #1;
        chk_out("in_rst2", 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_out("post_rst", 1'b1, 1'b1, 1'b1, 5'd0, 1'b1, 4'd0, 1'b0);
        cyc(1'b1, 20'h3, 1'b1, 20'h4, 1'b0);
        chk_out("post_rst2", 1'b1, 1'b1, 1'b1, 5'd1, 1'b1, 4'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
